// File: rtl/sram_arbiter.sv
// sram_arbiter
// Two-requester controller for an external asynchronous SRAM (256K x 16).
// Requesters 0 and 1 present read/write commands. A round-robin arbiter in
// IDLE picks one command, which then drives the SRAM strobes for WAIT_CYCLES
// cycles (ACCESS), spends one cycle with the strobes released (DONE), and
// returns to IDLE. Every SRAM output and every response is a flop.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         command handshake, requester N (N = 0, 1)
//   reqN_we/be/addr/wdata    command: write flag, byte enables, address, data
//   respN_valid/rdata        one-cycle completion pulse and read data
//   ram_adr                  SRAM word address
//   ram_dat_out/ram_dat_oe   write data and tristate enable for the chip top
//   ram_dat_in               data coming back from the SRAM pins
//   ram_cs_n/oe_n/we_n       active-low chip select, output and write enables
//   ram_lb_n/ub_n            active-low lower/upper byte-lane strobes
//   dbg_state                current FSM state (IDLE=0, ACCESS=1, DONE=2)
//
// Handshake: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both high. ready is only ever high in IDLE, and only for the
// requester that wins arbitration, so at most one command transfers per
// edge. A requester holds valid and its command stable until ready; dropping
// valid before ready withdraws the command, which is then never serviced.
module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [1:0]        req0_be,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [1:0]        req1_be,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic [ADDR_W-1:0] ram_adr,
    output logic [DATA_W-1:0] ram_dat_out,
    output logic              ram_dat_oe,
    input  logic [DATA_W-1:0] ram_dat_in,
    output logic              ram_cs_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              ram_lb_n,
    output logic              ram_ub_n,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1 so that ACCESS lasts exactly
    // WAIT_CYCLES cycles (legal WAIT_CYCLES is 1..15).
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        last_grant;   // id granted most recently; ties go to the other one
    logic        cur_id;       // id of the command in flight
    logic        cur_we;       // in-flight command is a write

    logic              any_valid;
    logic              grant_id;
    logic              sel_we;
    logic [1:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Sole valid requester wins; on a tie the one not granted last time wins.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    assign req0_ready = (state == IDLE) & any_valid & ~grant_id;
    assign req1_ready = (state == IDLE) & any_valid &  grant_id;

    assign sel_we    = grant_id ? req1_we    : req0_we;
    assign sel_be    = grant_id ? req1_be    : req0_be;
    assign sel_addr  = grant_id ? req1_addr  : req0_addr;
    assign sel_wdata = grant_id ? req1_wdata : req0_wdata;

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_we      <= 1'b0;
            ram_adr     <= '0;
            ram_dat_out <= '0;
            ram_dat_oe  <= 1'b0;
            ram_cs_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_lb_n    <= 1'b1;
            ram_ub_n    <= 1'b1;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_rdata <= '0;
            resp1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                        cur_we     <= sel_we;
                        wait_cnt   <= CNT_LOAD;
                        ram_adr    <= sel_addr;
                        ram_cs_n   <= 1'b0;
                        if (sel_we) begin
                            ram_we_n    <= 1'b0;
                            ram_oe_n    <= 1'b1;
                            ram_lb_n    <= ~sel_be[0];
                            ram_ub_n    <= ~sel_be[1];
                            ram_dat_oe  <= 1'b1;
                            ram_dat_out <= sel_wdata;
                        end else begin
                            // Reads always fetch both lanes; be is ignored.
                            ram_we_n   <= 1'b1;
                            ram_oe_n   <= 1'b0;
                            ram_lb_n   <= 1'b0;
                            ram_ub_n   <= 1'b0;
                            ram_dat_oe <= 1'b0;
                        end
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Strobes release here; for writes the address, data
                        // and data enable stay put through DONE as hold time.
                        ram_cs_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        ram_lb_n <= 1'b1;
                        ram_ub_n <= 1'b1;
                        if (!cur_we) begin
                            // oe_n is still low at this edge, so the pins
                            // carry valid read data.
                            if (cur_id) resp1_rdata <= ram_dat_in;
                            else        resp0_rdata <= ram_dat_in;
                        end
                        if (cur_id) resp1_valid <= 1'b1;
                        else        resp0_valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                DONE: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    ram_dat_oe  <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Bench for sram_arbiter: a behavioural SRAM on the pins, a reference model
// that predicts handshakes, strobes and responses from the access timeline,
// directed scenarios followed by randomized traffic, and a summary line.
module tb_sram_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;
    localparam int W      = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              req0_valid, req0_ready, req0_we;
    logic [1:0]        req0_be;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [1:0]        req1_be;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_dat_out, ram_dat_in;
    logic              ram_dat_oe, ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
    logic [1:0]        dbg_state;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .ram_adr(ram_adr), .ram_dat_out(ram_dat_out), .ram_dat_oe(ram_dat_oe),
        .ram_dat_in(ram_dat_in),
        .ram_cs_n(ram_cs_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
        .dbg_state(dbg_state)
    );

    // ---------------- SRAM pin model ----------------
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    assign ram_dat_in = (!ram_cs_n && !ram_oe_n) ? mem[ram_adr] : 16'hDEAD;
    always @(negedge clk) begin
        if (!ram_cs_n && !ram_we_n) begin
            if (!ram_lb_n) mem[ram_adr][7:0]  <= ram_dat_out[7:0];
            if (!ram_ub_n) mem[ram_adr][15:8] <= ram_dat_out[15:8];
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: one access at a time, timeline relative to the accept
    // cycle a: ACCESS a+1..a+W, DONE a+W+1, free again from a+W+2.
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_rdata [2];
    logic [ADDR_W-1:0] m_adr = '0;
    bit                busy = 1'b0;
    bit                lg = 1'b1;
    int                acc_c = 0;
    bit                c_id, c_we;
    logic [1:0]        c_be;
    logic [DATA_W-1:0] c_wd;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    always begin
        logic [5:0]        exp_str;
        logic [DATA_W-1:0] old, nw, e;
        bit                in_acc, in_done, due0, due1, er0, er1;
        @(negedge clk);
        #4;
        if (rst) begin
            chk("rst_strobes", {ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_dat_oe}, 6'b111110);
            chk("rst_adr", ram_adr, 0);
            chk("rst_resp_valid", {resp0_valid, resp1_valid}, 0);
            chk("rst_rdata", {resp0_rdata, resp1_rdata}, 0);
            busy = 0; lg = 1; m_adr = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
            exp_q.delete();
        end else begin
            if (busy && cyc > acc_c + W + 1) busy = 0;
            in_acc  = busy && cyc >= acc_c + 1 && cyc <= acc_c + W;
            in_done = busy && cyc == acc_c + W + 1;
            if (in_acc)
                exp_str = c_we ? {1'b0, 1'b1, 1'b0, ~c_be[0], ~c_be[1], 1'b1} : 6'b001000;
            else if (in_done)
                exp_str = {5'b11111, c_we};
            else
                exp_str = 6'b111110;
            chk("strobes", {ram_cs_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_dat_oe}, exp_str);
            chk("ram_adr", ram_adr, m_adr);
            if (exp_str[0]) chk("ram_dat_out", ram_dat_out, c_wd);

            due0 = in_done && !c_id;
            due1 = in_done &&  c_id;
            if (in_done) begin
                e = exp_q.pop_front();
                if (!c_we) m_rdata[c_id] = e;
            end
            if (resp0_valid || due0) chk("resp0_valid", resp0_valid, due0);
            if (resp1_valid || due1) chk("resp1_valid", resp1_valid, due1);
            chk("resp0_rdata", resp0_rdata, m_rdata[0]);
            chk("resp1_rdata", resp1_rdata, m_rdata[1]);

            er0 = !busy && req0_valid && (!req1_valid || lg);
            er1 = !busy && req1_valid && (!req0_valid || !lg);
            chk("req0_ready", req0_ready, er0);
            chk("req1_ready", req1_ready, er1);
            if (er0 || er1) begin
                c_id  = er1;
                c_we  = er1 ? req1_we    : req0_we;
                c_be  = er1 ? req1_be    : req0_be;
                c_wd  = er1 ? req1_wdata : req0_wdata;
                m_adr = er1 ? req1_addr  : req0_addr;
                acc_c = cyc; busy = 1; lg = er1;
                old = ref_rd(m_adr);
                if (c_we) begin
                    nw = {c_be[1] ? c_wd[15:8] : old[15:8], c_be[0] ? c_wd[7:0] : old[7:0]};
                    ref_mem[int'(m_adr)] = nw;
                    exp_q.push_back(nw);
                end else begin
                    exp_q.push_back(old);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int grant_log[$];

    task automatic drive(input int id, input bit v, input bit we, input logic [1:0] be,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (id == 0) begin
            req0_valid = v; req0_we = we; req0_be = be; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_be = be; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Called at a falling edge; returns at the falling edge inside the first
    // ACCESS cycle. keep leaves valid high for a follow-on command.
    task automatic send(input int id, input bit we, input logic [1:0] be,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit keep, output int acc);
        bit got = 0;
        acc = -1;
        drive(id, 1'b1, we, be, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            #4;
            if ((id == 0) ? req0_ready : req1_ready) begin
                got = 1; acc = cyc; grant_log.push_back(id);
            end
            @(negedge clk);
        end
        chk("send_accepted", got, 1);
        if (!keep || !got) drive(id, 1'b0, we, be, a, d);
    endtask

    task automatic wait_resp(input int id, output int rc);
        bit found = 0;
        rc = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            #4;
            if ((id == 0) ? resp0_valid : resp1_valid) begin
                found = 1; rc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("resp_seen", found, 1);
    endtask

    task automatic wait_done();
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed %0d expected <200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int acc, acc2, acc3, rc, nlow;
        logic [ADDR_W-1:0] pa;
        rst = 1'b1;
        drive(0, 0, 0, 2'b00, '0, '0);
        drive(1, 0, 0, 2'b00, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_cs_n", ram_cs_n, 1);
        chk("reset_dat_oe", ram_dat_oe, 0);
        chk("reset_adr", ram_adr, 0);
        chk("reset_dat_out", ram_dat_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read-back; write pulse length and read latency.
        send(0, 1, 2'b11, 18'h12345, 16'hBEEF, 0, acc);
        nlow = 0;
        for (int i = 0; i < W + 2; i++) begin
            #4;
            if (!ram_we_n) nlow++;
            @(negedge clk);
        end
        chk("t1_we_pulse_cycles", nlow, W);
        send(0, 0, 2'b00, 18'h12345, 16'h0000, 0, acc);
        wait_resp(0, rc);
        chk("t1_read_latency", rc - acc, W + 1);
        chk("t1_rdata", resp0_rdata, 16'hBEEF);
        @(negedge clk);

        // Byte-lane merge.
        send(0, 1, 2'b11, 18'h00100, 16'hAA55, 0, acc);
        wait_done();
        send(0, 1, 2'b10, 18'h00100, 16'h1200, 0, acc);
        #1;
        chk("t3_lanes_lb_ub", {ram_lb_n, ram_ub_n}, 2'b10);
        wait_done();
        send(0, 0, 2'b00, 18'h00100, 16'h0000, 0, acc);
        wait_resp(0, rc);
        chk("t3_rdata_merged", resp0_rdata, 16'h1255);
        @(negedge clk);

        // Fully masked write leaves memory alone but still responds.
        send(0, 1, 2'b11, 18'h00200, 16'h5A5A, 0, acc);
        wait_done();
        send(0, 1, 2'b00, 18'h00200, 16'hFFFF, 0, acc);
        wait_resp(0, rc);
        chk("t6_masked_write_resp_latency", rc - acc, W + 1);
        @(negedge clk);
        send(0, 0, 2'b00, 18'h00200, 16'h0000, 0, acc);
        wait_resp(0, rc);
        chk("t6_rdata_unchanged", resp0_rdata, 16'h5A5A);
        @(negedge clk);

        // Back-to-back reads with valid held: accepts every W+2 cycles.
        send(0, 0, 2'b00, 18'h12345, 16'h0000, 1, acc);
        send(0, 0, 2'b00, 18'h00100, 16'h0000, 1, acc2);
        send(0, 0, 2'b00, 18'h00200, 16'h0000, 0, acc3);
        chk("t4_gap_1", acc2 - acc, W + 2);
        chk("t4_gap_2", acc3 - acc2, W + 2);
        wait_done();

        // Asynchronous reset in the first ACCESS cycle of a write.
        send(0, 1, 2'b11, 18'h00777, 16'h1111, 0, acc);
        #1;
        chk("t5_we_n_before_rst", ram_we_n, 0);
        rst = 1'b1;
        #1;
        chk("t5_async_we_n", ram_we_n, 1);
        chk("t5_async_cs_n", ram_cs_n, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            #4;
            chk("t5_no_resp0", resp0_valid, 0);
            @(negedge clk);
        end

        // Round-robin with both requesters continuously valid.
        grant_log.delete();
        fork
            begin
                int a0, a1;
                send(0, 0, 2'b00, 18'h12345, 16'h0000, 1, a0);
                send(0, 0, 2'b00, 18'h00200, 16'h0000, 0, a1);
            end
            begin
                int b0, b1;
                send(1, 0, 2'b00, 18'h00100, 16'h0000, 1, b0);
                send(1, 0, 2'b00, 18'h12345, 16'h0000, 0, b1);
            end
        join
        wait_done();
        chk("t2_grant_count", grant_log.size(), 4);
        for (int k = 0; k < grant_log.size() && k < 4; k++)
            chk("t2_grant_order", grant_log[k], k % 2);
        chk("t2_resp0_rdata", resp0_rdata, 16'h5A5A);
        chk("t2_resp1_rdata", resp1_rdata, 16'hBEEF);

        // Randomized traffic over a small address pool.
        for (int k = 0; k < 8; k++) begin
            send(k % 2, 1, 2'b11, 18'h3F000 + 18'(k), 16'($urandom), 0, acc);
            wait_done();
        end
        for (int n = 0; n < 40; n++) begin
            int mode;
            bit we0, we1;
            logic [1:0] be0, be1;
            logic [ADDR_W-1:0] a0, a1;
            logic [DATA_W-1:0] d0, d1;
            mode = $urandom_range(0, 2);
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            be0 = 2'($urandom_range(0, 3)); be1 = 2'($urandom_range(0, 3));
            a0 = 18'h3F000 + 18'($urandom_range(0, 7));
            a1 = 18'h3F000 + 18'($urandom_range(0, 7));
            d0 = 16'($urandom); d1 = 16'($urandom);
            if (mode == 2) begin
                fork
                    begin int x; send(0, we0, be0, a0, d0, 0, x); end
                    begin int y; send(1, we1, be1, a1, d1, 0, y); end
                join
            end else if (mode == 1) begin
                send(1, we1, be1, a1, d1, 0, acc);
            end else begin
                send(0, we0, be0, a0, d0, 0, acc);
            end
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        pa = 18'h3F000;
        send(0, 0, 2'b00, pa, 16'h0000, 0, acc);
        wait_resp(0, rc);
        chk("rand_final_read", resp0_rdata, ref_rd(pa));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
